// File: rtl/loader_seq_pkg.sv
// Shared types and constants for the loader test sequencer: FSM states,
// the buffered command record and the field widths used on the loader side.
package loader_seq_pkg;

    localparam int PMU_ADDR_W   = 5;
    localparam int LOADER_ID_W  = 5;
    localparam int LOADER_SEL_W = 8;
    localparam int AXLEN_W      = 8;
    localparam int PMU_DATA_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        START,
        WAIT_IDLE,
        COLLECT
    } seq_state_t;

    // loader is kept wider than $clog2(N) so out-of-range targets stay detectable
    typedef struct packed {
        logic [LOADER_SEL_W-1:0] loader;
        logic [LOADER_ID_W-1:0]  id;
        logic                    write;
        logic [AXLEN_W-1:0]      axlen;
    } seq_cmd_t;

endpackage

// File: rtl/seq_cmd_fifo.sv
// Command buffer for the sequencer: synchronous FIFO of seq_cmd_t with
// full/empty flags and a one-entry-left flag used to end dispatch on the last pop.
module seq_cmd_fifo
    import loader_seq_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  seq_cmd_t push_data,
    input  logic     pop,
    output seq_cmd_t pop_data,
    output logic     full,
    output logic     empty,
    output logic     last
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    seq_cmd_t       mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic [AW:0]    count;

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop && !empty)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Extra pointer MSB separates a full buffer from an empty one
    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign last     = (count == ONE);
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/loader_test_sequencer.sv
// Run control for the loader mesh: buffer host commands, dispatch, start, wait idle,
// sweep PMUs to the host. Optional WAIT_IDLE watchdog enabled by SEQ_TIMEOUT_EN.
module loader_test_sequencer
    import loader_seq_pkg::*;
#(
    parameter int N              = 16,
    parameter int CMD_DEPTH      = 32,
    parameter int PMU_REGS       = 8,
    parameter int IDLE_SETTLE    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                  clk_i,
    input  logic                                  arst_i,
    input  logic                                  cmd_valid_i,
    output logic                                  cmd_ready_o,
    input  logic [$clog2(N)-1:0]                  cmd_loader_i,
    input  logic [LOADER_ID_W-1:0]                cmd_id_i,
    input  logic                                  cmd_write_i,
    input  logic [AXLEN_W-1:0]                    cmd_axlen_i,
    input  logic                                  go_i,
    input  logic [N-1:0]                          resp_wait_mask_i,
    output logic                                  busy_o,
    output logic [N-1:0]                          fifo_push_o,
    output logic [N-1:0][LOADER_ID_W-1:0]         id_o,
    output logic [N-1:0]                          write_o,
    output logic [N-1:0][AXLEN_W-1:0]             axlen_o,
    output logic [N-1:0]                          resp_wait_o,
    output logic                                  start_o,
    input  logic [N-1:0]                          idle_i,
    output logic [N-1:0][PMU_ADDR_W-1:0]          pmu_addr_o,
    input  logic [N-1:0][PMU_DATA_W-1:0]          pmu_data_i,
    output logic                                  res_valid_o,
    input  logic                                  res_ready_i,
    output logic [$clog2(N)-1:0]                  res_loader_o,
    output logic [PMU_ADDR_W-1:0]                 res_addr_o,
    output logic [PMU_DATA_W-1:0]                 res_data_o,
    output logic                                  res_last_o,
    output logic                                  err_o
);

    localparam int LW       = $clog2(N);
    localparam int SETTLE_W = ($clog2(IDLE_SETTLE + 1) > 0) ? $clog2(IDLE_SETTLE + 1) : 1;
    localparam logic [LOADER_SEL_W-1:0] N_SEL       = LOADER_SEL_W'(N);
    localparam logic [LW-1:0]           LOADER_LAST = LW'(N - 1);
    localparam logic [PMU_ADDR_W-1:0]   ADDR_LAST   = PMU_ADDR_W'(PMU_REGS - 1);

    if (PMU_REGS < 1 || PMU_REGS > 32 || TIMEOUT_CYCLES < 1 ||
        CMD_DEPTH != (1 << $clog2(CMD_DEPTH))) begin : g_bad_params
        $error("loader_test_sequencer: illegal parameter set");
    end

    seq_state_t             state_reg;
    seq_cmd_t               cmd_in;
    seq_cmd_t               fifo_rd_data;
    logic                   fifo_full, fifo_empty, fifo_last;
    logic                   cmd_accept, fifo_pop;
    logic [N-1:0]           dispatch_onehot;

    logic [N-1:0]           push_reg;
    logic [LOADER_ID_W-1:0] id_reg;
    logic                   write_reg;
    logic [AXLEN_W-1:0]     axlen_reg;
    logic [N-1:0]           resp_wait_reg;
    logic                   start_reg;
    logic [SETTLE_W-1:0]    settle_reg;
    logic                   idle_seen_reg;
    logic [LW-1:0]          loader_reg;
    logic [PMU_ADDR_W-1:0]  addr_reg;
    logic                   res_valid_reg;
    logic [LW-1:0]          res_loader_reg;
    logic [PMU_ADDR_W-1:0]  res_addr_reg;
    logic [PMU_DATA_W-1:0]  res_data_reg;
    logic                   res_last_reg;
    logic                   err_reg;
`ifdef SEQ_TIMEOUT_EN
    logic [31:0]            timeout_cnt_reg;
`endif

    assign cmd_ready_o = (state_reg == IDLE) && !fifo_full;
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;
    assign fifo_pop    = (state_reg == DISPATCH) && !fifo_empty;
    assign cmd_in      = '{loader: LOADER_SEL_W'(cmd_loader_i), id: cmd_id_i,
                           write: cmd_write_i, axlen: cmd_axlen_i};

    seq_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk_i),
        .rst       (arst_i),
        .push      (cmd_accept),
        .push_data (cmd_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .last      (fifo_last)
    );

    // Loader-side fields are broadcast; only the pushed loader captures them
    for (genvar gi = 0; gi < N; gi++) begin : g_loader
        assign dispatch_onehot[gi] = (fifo_rd_data.loader == LOADER_SEL_W'(gi));
        assign id_o[gi]            = id_reg;
        assign write_o[gi]         = write_reg;
        assign axlen_o[gi]         = axlen_reg;
        assign pmu_addr_o[gi]      = addr_reg;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg      <= IDLE;
            push_reg       <= '0;
            id_reg         <= '0;
            write_reg      <= 1'b0;
            axlen_reg      <= '0;
            resp_wait_reg  <= '0;
            start_reg      <= 1'b0;
            settle_reg     <= '0;
            idle_seen_reg  <= 1'b0;
            loader_reg     <= '0;
            addr_reg       <= '0;
            res_valid_reg  <= 1'b0;
            res_loader_reg <= '0;
            res_addr_reg   <= '0;
            res_data_reg   <= '0;
            res_last_reg   <= 1'b0;
            err_reg        <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            timeout_cnt_reg <= '0;
`endif
        end else begin
            push_reg  <= '0;
            start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (go_i) begin
                        resp_wait_reg <= resp_wait_mask_i;
                        state_reg     <= (fifo_empty && !cmd_accept) ? START : DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (!fifo_empty) begin
                        id_reg    <= fifo_rd_data.id;
                        write_reg <= fifo_rd_data.write;
                        axlen_reg <= fifo_rd_data.axlen;
                        if (fifo_rd_data.loader < N_SEL)
                            push_reg <= dispatch_onehot;
                        else
                            err_reg <= 1'b1;
                        if (fifo_last)
                            state_reg <= START;
                    end else begin
                        state_reg <= START;
                    end
                end
                START: begin
                    start_reg     <= 1'b1;
                    settle_reg    <= SETTLE_W'(IDLE_SETTLE);
                    idle_seen_reg <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                    timeout_cnt_reg <= '0;
`endif
                    state_reg     <= WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    // Idle must hold on two consecutive samples after the settle window
                    if (settle_reg != '0) begin
                        settle_reg <= settle_reg - 1'b1;
                    end else if (&idle_i) begin
                        idle_seen_reg <= 1'b1;
                        if (idle_seen_reg) begin
                            state_reg  <= COLLECT;
                            loader_reg <= '0;
                            addr_reg   <= '0;
                        end
                    end else begin
                        idle_seen_reg <= 1'b0;
                    end
`ifdef SEQ_TIMEOUT_EN
                    if (timeout_cnt_reg == 32'(TIMEOUT_CYCLES - 1)) begin
                        err_reg    <= 1'b1;
                        state_reg  <= COLLECT;
                        loader_reg <= '0;
                        addr_reg   <= '0;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
`endif
                end
                COLLECT: begin
                    // Address is presented while valid is low; data is captured one cycle later
                    if (!res_valid_reg) begin
                        res_valid_reg  <= 1'b1;
                        res_loader_reg <= loader_reg;
                        res_addr_reg   <= addr_reg;
                        res_data_reg   <= pmu_data_i[loader_reg];
                        res_last_reg   <= (loader_reg == LOADER_LAST) && (addr_reg == ADDR_LAST);
                    end else if (res_ready_i) begin
                        res_valid_reg <= 1'b0;
                        res_last_reg  <= 1'b0;
                        if (res_last_reg) begin
                            state_reg <= IDLE;
                            addr_reg  <= '0;
                        end else if (addr_reg == ADDR_LAST) begin
                            addr_reg   <= '0;
                            loader_reg <= loader_reg + 1'b1;
                        end else begin
                            addr_reg <= addr_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy_o       = (state_reg != IDLE);
    assign fifo_push_o  = push_reg;
    assign resp_wait_o  = resp_wait_reg;
    assign start_o      = start_reg;
    assign res_valid_o  = res_valid_reg;
    assign res_loader_o = res_loader_reg;
    assign res_addr_o   = res_addr_reg;
    assign res_data_o   = res_data_reg;
    assign res_last_o   = res_last_reg;
    assign err_o        = err_reg;

endmodule

// File: tb/tb_loader_test_sequencer.sv
// Scoreboard bench for loader_test_sequencer: dispatch order, start timing,
// idle gating and the PMU sweep; the SEQ_TIMEOUT_EN build exercises the watchdog.
module tb_loader_test_sequencer;
    import loader_seq_pkg::*;

    localparam int N         = 16;
    localparam int CMD_DEPTH = 32;
    localparam int PMU_REGS  = 8;
    localparam int LW        = 4;

    typedef struct {
        logic [LW-1:0]  loader;
        logic [4:0]     addr;
        logic [31:0]    data;
        logic           last;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   arst = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [LW-1:0]          cmd_loader = '0;
    logic [4:0]             cmd_id = '0;
    logic                   cmd_write = 1'b0;
    logic [7:0]             cmd_axlen = '0;
    logic                   go = 1'b0;
    logic [N-1:0]           resp_wait_mask = '0;
    logic                   busy;
    logic [N-1:0]           fifo_push;
    logic [N-1:0][4:0]      id;
    logic [N-1:0]           write;
    logic [N-1:0][7:0]      axlen;
    logic [N-1:0]           resp_wait;
    logic                   start;
    logic [N-1:0]           idle = '1;
    logic [N-1:0][4:0]      pmu_addr;
    logic [N-1:0][31:0]     pmu_data;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [LW-1:0]          res_loader;
    logic [4:0]             res_addr;
    logic [31:0]            res_data;
    logic                   res_last;
    logic                   err;

    int n_checks = 0;
    int n_fail   = 0;
    seq_cmd_t dq[$];
    beat_t    cq[$];

    always #5 clk = ~clk;

    loader_test_sequencer #(
        .N(N), .CMD_DEPTH(CMD_DEPTH), .PMU_REGS(PMU_REGS), .IDLE_SETTLE(4), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk_i(clk), .arst_i(arst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_loader_i(cmd_loader),
        .cmd_id_i(cmd_id), .cmd_write_i(cmd_write), .cmd_axlen_i(cmd_axlen),
        .go_i(go), .resp_wait_mask_i(resp_wait_mask), .busy_o(busy),
        .fifo_push_o(fifo_push), .id_o(id), .write_o(write), .axlen_o(axlen),
        .resp_wait_o(resp_wait), .start_o(start), .idle_i(idle),
        .pmu_addr_o(pmu_addr), .pmu_data_i(pmu_data),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_loader_o(res_loader),
        .res_addr_o(res_addr), .res_data_o(res_data), .res_last_o(res_last), .err_o(err)
    );

    // PMU model: loader l returns l*256 + addr
    for (genvar gi = 0; gi < N; gi++) begin : g_pmu
        assign pmu_data[gi] = 32'(gi) * 32'd256 + 32'(pmu_addr[gi]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int l, input int i, input bit w, input int len);
        seq_cmd_t c;
        cmd_valid  = 1'b1;
        cmd_loader = LW'(l);
        cmd_id     = 5'(i);
        cmd_write  = w;
        cmd_axlen  = 8'(len);
        c = '{loader: 8'(l), id: 5'(i), write: w, axlen: 8'(len)};
        dq.push_back(c);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic dispatch_monitor(input int budget, output int pushes,
                                    output int first_c, output int last_c, output int start_c);
        seq_cmd_t e;
        pushes = 0; first_c = -1; last_c = -1; start_c = -1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (|fifo_push) begin
                pushes++;
                if (dq.size() == 0) begin
                    check("dispatch_extra_push", 32'(fifo_push), 32'd0);
                end else begin
                    e = dq.pop_front();
                    check("push_onehot", 32'(fifo_push), 32'd1 << e.loader);
                    check("push_id", 32'(id[e.loader[LW-1:0]]), 32'(e.id));
                    check("push_write", 32'(write[e.loader[LW-1:0]]), 32'(e.write));
                    check("push_axlen", 32'(axlen[e.loader[LW-1:0]]), 32'(e.axlen));
                end
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (start && start_c < 0) start_c = c;
        end
    endtask

    task automatic run_collect(input bit rand_ready, output int first_hs, output int last_hs);
        beat_t b;
        cq.delete();
        for (int l = 0; l < N; l++)
            for (int r = 0; r < PMU_REGS; r++) begin
                b.loader = LW'(l);
                b.addr   = 5'(r);
                b.data   = 32'(l * 256 + r);
                b.last   = (l == N - 1) && (r == PMU_REGS - 1);
                cq.push_back(b);
            end
        first_hs = -1; last_hs = -1;
        for (int c = 0; c < 3000 && cq.size() > 0; c++) begin
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (res_valid && res_ready) begin
                b = cq.pop_front();
                check("res_loader", 32'(res_loader), 32'(b.loader));
                check("res_addr", 32'(res_addr), 32'(b.addr));
                check("res_data", res_data, b.data);
                check("res_last", 32'(res_last), 32'(b.last));
                if (first_hs < 0) first_hs = c;
                last_hs = c;
            end
            tick();
        end
        res_ready = 1'b0;
        check("collect_beats_missing", 32'(cq.size()), 32'd0);
        tick();
        check("collect_busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int pushes, first_c, last_c, start_c, first_hs, last_hs, k;
        bit seen;

        // Reset state
        arst = 1'b1;
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_push_start", 32'({fifo_push, start}), 32'd0);
        arst = 1'b0;
        tick();

        // Three commands; the third is accepted in the same cycle as go
        send_cmd(2, 1, 1'b1, 3);
        send_cmd(5, 2, 1'b0, 0);
        go = 1'b1;
        resp_wait_mask = 16'hA5C3;
        send_cmd(2, 3, 1'b0, 7);
        go = 1'b0;
        dispatch_monitor(12, pushes, first_c, last_c, start_c);
        check("small_push_count", 32'(pushes), 32'd3);
        check("small_push_consecutive", 32'(last_c - first_c), 32'd2);
        check("small_start_after_push", 32'(start_c), 32'(last_c + 1));
        check("resp_wait_latched", 32'(resp_wait), 32'hA5C3);
        check("busy_in_run", 32'(busy), 32'd1);
        run_collect(1'b0, first_hs, last_hs);
        check("collect_throughput", 32'(last_hs - first_hs), 32'd254);

        // Fill the buffer; an extra command while full must be ignored
        for (int i = 0; i < CMD_DEPTH; i++)
            send_cmd(i % N, i, 1'(i), (i * 7) % 256);
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        cmd_loader = 4'd3;
        tick();
        cmd_valid = 1'b0;
        idle = '0;
        go = 1'b1;
        resp_wait_mask = 16'h0F0F;
        tick();
        go = 1'b0;
        dispatch_monitor(45, pushes, first_c, last_c, start_c);
        check("full_push_count", 32'(pushes), 32'd32);
        check("full_start_after_push", 32'(start_c), 32'(last_c + 1));
        check("resp_wait_relatched", 32'(resp_wait), 32'h0F0F);

`ifdef SEQ_TIMEOUT_EN
        // Idle never asserts: watchdog fires on cycle 50 of WAIT_IDLE
        k = 44 - start_c;
        while (!err && k < 200) begin
            tick();
            k++;
        end
        check("timeout_cycle", 32'(k), 32'd50);
        check("timeout_err", 32'(err), 32'd1);
        run_collect(1'b1, first_hs, last_hs);
`else
        // Loaders stay busy: no result beat may appear
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check("hold_no_beat", 32'(seen), 32'd0);
        idle = '1;
        k = 0;
        while (!res_valid && k < 10) begin
            tick();
            k++;
        end
        check("release_latency_ok", 32'(k <= 3), 32'd1);
        run_collect(1'b1, first_hs, last_hs);
        check("err_clear_default", 32'(err), 32'd0);
`endif

        // Reset mid-COLLECT, then a fresh run must start from loader 0 addr 0
        idle = '1;
        go = 1'b1;
        tick();
        go = 1'b0;
        k = 0;
        while (!res_valid && k < 30) begin
            tick();
            k++;
        end
        check("midrun_reached_collect", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        repeat (6) tick();
        res_ready = 1'b0;
        #3 arst = 1'b1;
        #1;
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("arst_outputs", 32'({err, start, res_last, |fifo_push, |resp_wait}), 32'd0);
        check("arst_pmu_addr", 32'(pmu_addr[0]), 32'd0);
        tick();
        arst = 1'b0;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        run_collect(1'b1, first_hs, last_hs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/loader_test_sequencer.md
Name: loader_test_sequencer

Overview:
- Run-control block for the cosimulation mesh with traffic loaders.
- Buffers host-issued traffic commands, distributes them into the per-loader command FIFOs, fires a common start, waits for all loaders to drain, then sweeps every loader's PMU register file and streams the counters back to the host.
- Sits between the cosim host interface and the mesh_with_loaders control/PMU ports.

Parameters:
- N, 16, number of loaders/PMUs driven.
- CMD_DEPTH, 32, depth of the internal command buffer (power of two).
- PMU_REGS, 8, PMU addresses swept per loader (0..PMU_REGS-1), ≤32.
- IDLE_SETTLE, 4, cycles after start before idle_i is trusted.
- TIMEOUT_CYCLES, 65535, WAIT_IDLE limit (used only with SEQ_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  host command valid
- cmd_ready_o  out  1  command buffer not full and FSM in IDLE
- cmd_loader_i  in  $clog2(N)  target loader
- cmd_id_i  in  5  AXI ID field
- cmd_write_i  in  1  1=write burst, 0=read burst
- cmd_axlen_i  in  8  burst length-1
- go_i  in  1  start a run (sampled in IDLE only)
- resp_wait_mask_i  in  N  per-loader resp_wait, latched on go
- busy_o  out  1  FSM not IDLE
- fifo_push_o  out  [N]x1  one-hot push to loader FIFO
- id_o, write_o, axlen_o, resp_wait_o  out  [N]x5/1/8/1  loader fields
- start_o  out  1  common start pulse
- idle_i  in  [N]x1  loader idle flags
- pmu_addr_o  out  [N]x5  PMU register address (same value to all)
- pmu_data_i  in  [N]x32  PMU read data (combinational on pmu_addr_o)
- res_valid_o, res_ready_i  out/in  1  result stream handshake
- res_loader_o  out  $clog2(N), res_addr_o  out  5, res_data_o  out  32, res_last_o  out  1
- err_o  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0, except cmd_ready_o=1. Buffer is emptied; FSM goes to IDLE.
- IDLE:
  - Command accepted when cmd_valid_i && cmd_ready_o; one entry per cycle.
  - When the buffer is full, cmd_ready_o=0.
  - go_i=1 latches resp_wait_mask_i and moves to DISPATCH. If the buffer is empty, go skips DISPATCH and goes straight to START.
  - go_i and a command accepted in the same cycle: the command is included in the run.
- DISPATCH:
  - Pops one entry per cycle.
  - fifo_push_o[cmd_loader] pulses 1 cycle; id/write/axlen driven to all loaders, so only the pushed loader captures.
  - Leaves to START in the cycle after the last pop.
  - cmd_loader ≥ N: entry dropped, err_o set, no push.
- START:
  - start_o high exactly 1 cycle.
  - Settle counter loads IDLE_SETTLE; then WAIT_IDLE.
- WAIT_IDLE:
  - Counter decrements to 0.
  - Then exits when &idle_i is high for 2 consecutive cycles.
- COLLECT:
  - Loader-major loop: l=0..N-1, r=0..PMU_REGS-1.
  - pmu_addr_o=r; data sampled one cycle later from pmu_data_i[l] into the result register; res_valid_o asserted.
  - Fields stay stable until res_ready_i; next address is issued on the handshake.
  - Throughput: 1 result per 2 cycles when the consumer is always ready.
  - res_last_o=1 on (N-1, PMU_REGS-1). The handshake on that beat returns the FSM to IDLE.
- resp_wait_o holds the latched mask from go until the next go.
- busy_o=1 in all states except IDLE.
- err_o is cleared only by reset.
- Reset mid-run: all state discarded, no partial result beat.
- Buffer pointers are $clog2(CMD_DEPTH)+1 bits wide; the MSB distinguishes full from empty.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - 32-bit counter runs in WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES sets err_o and forces COLLECT, so counters are still reported.
- Undefined: WAIT_IDLE waits indefinitely; no counter logic.

Decomposition:
- Package loader_seq_pkg:
  - state enum (IDLE, DISPATCH, START, WAIT_IDLE, COLLECT)
  - packed seq_cmd_t {loader, id, write, axlen}
  - constants PMU_ADDR_W=5, LOADER_ID_W=5
- One sub-module: seq_cmd_fifo, a synchronous FIFO of seq_cmd_t with full/empty flags.
- FSM and collect loop stay in the top.

Test Plan:
- Reset with arst_i asserted mid-COLLECT -> all outputs 0, busy_o=0, cmd_ready_o=1, next run reports from loader 0 addr 0.
- Push 3 commands (loader 2 write axlen 3, loader 5 read axlen 0, loader 2 read axlen 7), then go -> fifo_push_o[2], [5], [2] on 3 consecutive cycles with matching fields; start_o one cycle later.
- Push CMD_DEPTH commands -> cmd_ready_o=0; extra cmd_valid_i is ignored; go dispatches exactly 32 entries.
- idle_i held low for 100 cycles after start -> no result beat; release -> COLLECT begins within 3 cycles.
- res_ready_i toggled randomly, pmu_data_i[l]=l*256+addr -> N*PMU_REGS=128 beats in order, loader 15 addr 7 data 0x0F07 with res_last_o=1.
- SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=50, idle_i stuck low -> err_o=1 at cycle 50 of WAIT_IDLE, full collect still completes.
